// File: rtl/cond_pkg.sv
// Shared condition-code encodings and flag bit positions
// for the Execute-stage condition/flag logic.
package cond_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_t;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator:
// decides whether Cond passes against Flags {N,Z,C,V}.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v, ge;

    assign n  = Flags[FLAG_N];
    assign z  = Flags[FLAG_Z];
    assign c  = Flags[FLAG_C];
    assign v  = Flags[FLAG_V];
    assign ge = (n == v);

    // Decode the condition field; never-condition yields 0
    always_comb begin
        CondEx = 1'b0;
        unique case (cond_t'(Cond))
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = ge;
            COND_LT: CondEx = ~ge;
            COND_GT: CondEx = ~z & ge;
            COND_LE: CondEx = z | ~ge;
            COND_AL: CondEx = 1'b1;
            COND_NV: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_cond_stage.sv
// Execute-stage condition unit: architectural flag register,
// condition gating of control, and the E/M pipeline register.
module ex_cond_stage
    import cond_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  ALUFlags,
    input  logic [31:0] ALUResultE,
    input  logic [31:0] WriteDataE,
    input  logic [3:0]  WA3E,
    input  logic [3:0]  CondE,
    input  logic [1:0]  FlagWriteE,
    input  logic        PCSrcE,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic        MemtoRegE,
    input  logic        BranchE,
    input  logic        StallE,
    input  logic        FlushE,
    output logic        CondExE,
    output logic        BranchTakenE,
    output logic [3:0]  FlagsQ,
    output logic [31:0] ALUResultM,
    output logic [31:0] WriteDataM,
    output logic [3:0]  WA3M,
    output logic        PCSrcM,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        MemtoRegM
);

    logic go;

    cond_check u_cond (
        .Cond   (CondE),
        .Flags  (FlagsQ),
        .CondEx (CondExE)
    );

    assign go           = CondExE & ~FlushE & ~StallE;
    assign BranchTakenE = BranchE & CondExE & ~FlushE;

    // Flag register: each pair updates only when selected and go
    always_ff @(posedge clk) begin
        if (reset) begin
            FlagsQ <= '0;
        end else if (go) begin
            if (FlagWriteE[1]) begin
                FlagsQ[FLAG_N] <= ALUFlags[FLAG_N];
                FlagsQ[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (FlagWriteE[0]) begin
                FlagsQ[FLAG_C] <= ALUFlags[FLAG_C];
                FlagsQ[FLAG_V] <= ALUFlags[FLAG_V];
            end
        end
    end

    // E/M register: reset/flush insert a bubble, stall holds
    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            ALUResultM <= '0;
            WriteDataM <= '0;
            WA3M       <= '0;
            PCSrcM     <= 1'b0;
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            MemtoRegM  <= 1'b0;
        end else if (!StallE) begin
            ALUResultM <= ALUResultE;
            WriteDataM <= WriteDataE;
            WA3M       <= WA3E;
            PCSrcM     <= PCSrcE & CondExE;
            RegWriteM  <= RegWriteE & CondExE;
            MemWriteM  <= MemWriteE & CondExE;
            MemtoRegM  <= MemtoRegE;
        end
    end

endmodule

// File: tb/tb_ex_cond_stage.sv
// Directed scoreboard bench for ex_cond_stage.
module tb_ex_cond_stage;

    logic        clk;
    logic        reset;
    logic [3:0]  ALUFlags;
    logic [31:0] ALUResultE;
    logic [31:0] WriteDataE;
    logic [3:0]  WA3E;
    logic [3:0]  CondE;
    logic [1:0]  FlagWriteE;
    logic        PCSrcE;
    logic        RegWriteE;
    logic        MemWriteE;
    logic        MemtoRegE;
    logic        BranchE;
    logic        StallE;
    logic        FlushE;
    logic        CondExE;
    logic        BranchTakenE;
    logic [3:0]  FlagsQ;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [3:0]  WA3M;
    logic        PCSrcM;
    logic        RegWriteM;
    logic        MemWriteM;
    logic        MemtoRegM;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [3:0]  wa3;
        logic        pcsrc;
        logic        regw;
        logic        memw;
        logic        mtr;
        logic [3:0]  flags;
    } exp_t;

    exp_t q[$];
    exp_t st;
    int   total = 0;
    int   bad = 0;

    ex_cond_stage dut (
        .clk          (clk),
        .reset        (reset),
        .ALUFlags     (ALUFlags),
        .ALUResultE   (ALUResultE),
        .WriteDataE   (WriteDataE),
        .WA3E         (WA3E),
        .CondE        (CondE),
        .FlagWriteE   (FlagWriteE),
        .PCSrcE       (PCSrcE),
        .RegWriteE    (RegWriteE),
        .MemWriteE    (MemWriteE),
        .MemtoRegE    (MemtoRegE),
        .BranchE      (BranchE),
        .StallE       (StallE),
        .FlushE       (FlushE),
        .CondExE      (CondExE),
        .BranchTakenE (BranchTakenE),
        .FlagsQ       (FlagsQ),
        .ALUResultM   (ALUResultM),
        .WriteDataM   (WriteDataM),
        .WA3M         (WA3M),
        .PCSrcM       (PCSrcM),
        .RegWriteM    (RegWriteM),
        .MemWriteM    (MemWriteM),
        .MemtoRegM    (MemtoRegM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference condition table, flags given as {N,Z,C,V}
    function automatic logic cond_ref(
        input logic [3:0] c,
        input logic [3:0] f
    );
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset      = 1'b0;
        ALUFlags   = 4'h0;
        CondE      = 4'he;
        FlagWriteE = 2'b00;
        PCSrcE     = 1'b0;
        RegWriteE  = 1'b0;
        MemWriteE  = 1'b0;
        MemtoRegE  = 1'b0;
        BranchE    = 1'b0;
        StallE     = 1'b0;
        FlushE     = 1'b0;
        ALUResultE = $urandom;
        WriteDataE = $urandom;
        WA3E       = 4'($urandom_range(0, 15));
    endtask

    // One clock: check comb outputs, push expected, pop after edge
    task automatic cycle(input string tag);
        logic ce;
        exp_t nx, got;
        #1;
        ce = cond_ref(CondE, st.flags);
        chk({tag, ".condex"}, 32'(CondExE), 32'(ce));
        chk({tag, ".brtaken"}, 32'(BranchTakenE),
            32'(BranchE & ce & ~FlushE));
        nx = st;
        if (reset) begin
            nx = '0;
        end else if (FlushE) begin
            nx = '0;
            nx.flags = st.flags;
        end else if (!StallE) begin
            nx.alu   = ALUResultE;
            nx.wd    = WriteDataE;
            nx.wa3   = WA3E;
            nx.pcsrc = PCSrcE & ce;
            nx.regw  = RegWriteE & ce;
            nx.memw  = MemWriteE & ce;
            nx.mtr   = MemtoRegE;
            if (ce && FlagWriteE[1]) nx.flags[3:2] = ALUFlags[3:2];
            if (ce && FlagWriteE[0]) nx.flags[1:0] = ALUFlags[1:0];
        end
        q.push_back(nx);
        @(posedge clk);
        #1;
        got = q.pop_front();
        st  = got;
        chk({tag, ".flags"}, 32'(FlagsQ), 32'(got.flags));
        chk({tag, ".alum"}, ALUResultM, got.alu);
        chk({tag, ".wdm"}, WriteDataM, got.wd);
        chk({tag, ".wa3m"}, 32'(WA3M), 32'(got.wa3));
        chk({tag, ".ctrl"},
            32'({PCSrcM, RegWriteM, MemWriteM, MemtoRegM}),
            32'({got.pcsrc, got.regw, got.memw, got.mtr}));
    endtask

    initial begin
        st = '0;
        idle();
        @(negedge clk);

        reset = 1'b1; MemtoRegE = 1'b1; RegWriteE = 1'b1;
        cycle("reset");

        idle();
        FlagWriteE = 2'b11; ALUFlags = 4'b0100; RegWriteE = 1'b1;
        cycle("al_set");
        chk("al_set.flags_lit", 32'(FlagsQ), 32'h4);
        chk("al_set.regw_lit", 32'(RegWriteM), 32'h1);

        idle();
        CondE = 4'b0001; RegWriteE = 1'b1; MemWriteE = 1'b1;
        FlagWriteE = 2'b11; ALUFlags = 4'b1111; PCSrcE = 1'b1;
        cycle("ne_fail");
        chk("ne_fail.lit", 32'({FlagsQ, RegWriteM, MemWriteM}),
            32'({4'b0100, 2'b00}));

        idle();
        FlagWriteE = 2'b11; ALUFlags = 4'b0000;
        cycle("clr");

        idle();
        CondE = 4'b0000; FlagWriteE = 2'b01; ALUFlags = 4'b1111;
        cycle("eq_fail");

        idle();
        FlagWriteE = 2'b01; ALUFlags = 4'b1111;
        cycle("cv_only");
        chk("cv_only.lit", 32'(FlagsQ), 32'h3);

        idle();
        FlagWriteE = 2'b11; ALUFlags = 4'b1001;
        cycle("set1001");

        idle();
        BranchE = 1'b1; CondE = 4'b1010; PCSrcE = 1'b1;
        MemtoRegE = 1'b1; RegWriteE = 1'b1;
        cycle("ge_br");

        idle();
        BranchE = 1'b1; CondE = 4'b1010; PCSrcE = 1'b1;
        FlushE = 1'b1; StallE = 1'b1; MemtoRegE = 1'b1;
        FlagWriteE = 2'b11; ALUFlags = 4'b0110;
        cycle("ge_flush");

        idle();
        RegWriteE = 1'b1; MemtoRegE = 1'b1;
        cycle("pre_stall");
        for (int i = 0; i < 2; i++) begin
            StallE = 1'b1; FlagWriteE = 2'b11;
            ALUFlags = 4'b0110; RegWriteE = 1'b0;
            ALUResultE = $urandom;
            cycle("stall");
        end
        StallE = 1'b0;
        cycle("release");
        chk("release.lit", 32'(FlagsQ), 32'h6);

        idle();
        CondE = 4'b0000; FlagWriteE = 2'b11; ALUFlags = 4'b1000;
        RegWriteE = 1'b1;
        cycle("b2b_eq");
        idle();
        CondE = 4'b0100; FlagWriteE = 2'b10; ALUFlags = 4'b0100;
        RegWriteE = 1'b1;
        cycle("b2b_mi");

        for (int f = 0; f < 16; f += 5) begin
            idle();
            FlagWriteE = 2'b11; ALUFlags = 4'(f);
            cycle("setf");
            for (int c = 0; c < 16; c++) begin
                idle();
                CondE = 4'(c); RegWriteE = 1'b1;
                MemWriteE = 1'b1; PCSrcE = 1'b1; BranchE = 1'b1;
                cycle("sweep");
            end
        end

        idle();
        FlagWriteE = 2'b11; ALUFlags = 4'b1111; RegWriteE = 1'b1;
        cycle("pre_rst");
        idle();
        reset = 1'b1; FlushE = 1'b1; StallE = 1'b1;
        FlagWriteE = 2'b11; ALUFlags = 4'b1010;
        cycle("rst_prio");
        chk("rst_prio.lit", 32'({FlagsQ, RegWriteM, WA3M}), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
